// File: rtl/draw_menu_select_if.sv
// VGA timing bus passed between stages of the menu draw chain.
// in/out are the stage-facing views; master/slave are the generic aliases.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport in     (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/draw_menu_select.sv
// Menu selection stage: highlight frame overlay plus the up/down/enter navigation FSM.
// Build option MENU_WRAP_EN: selection wraps at the menu ends instead of saturating.
package snake_pkg;
  localparam int RGB_B     = 12;
  localparam int BUTTONS_X = 312;
  localparam int BUTTONS_W = 176;
  localparam int BUTTONS_H = 48;
  localparam int BUTTON1_Y = 200;
  localparam int BUTTON2_Y = 280;
  localparam int BUTTON3_Y = 360;
endpackage

// state   | meaning
// BROWSE  | up/down move the selection, enter starts confirmation
// CONFIRM | highlight frame blinks, all buttons ignored
// DONE    | choice reported, held until en falls
module draw_menu_select
  import snake_pkg::*;
#(
  parameter logic [RGB_B-1:0] HL_COLOR       = 12'hF00,
  parameter int               FRAME_W        = 4,
  parameter int               BLINK_FRAMES   = 8,
  parameter int               CONFIRM_BLINKS = 3,
  parameter int               N_BUTTONS      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_enter,
  vga_if.in                vga_in,
  input  logic [RGB_B-1:0] rgb_i,
  vga_if.out               vga_out,
  output logic [RGB_B-1:0] rgb_o,
  output logic [1:0]       sel_o,
  output logic [1:0]       choice_o,
  output logic             choice_valid_o
);

  typedef enum logic [1:0] {
    BROWSE  = 2'd0,
    CONFIRM = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int BC_W = (2 * CONFIRM_BLINKS > 1) ? $clog2(2 * CONFIRM_BLINKS) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(2 * CONFIRM_BLINKS - 1);
  localparam logic [1:0]      SEL_MAX = 2'(N_BUTTONS - 1);

`ifdef MENU_WRAP_EN
  localparam logic [1:0] SEL_BELOW_MIN = SEL_MAX;
  localparam logic [1:0] SEL_ABOVE_MAX = 2'd0;
`else
  localparam logic [1:0] SEL_BELOW_MIN = 2'd0;
  localparam logic [1:0] SEL_ABOVE_MAX = SEL_MAX;
`endif

  localparam logic [11:0] X_LO_OUT = (BUTTONS_X >= FRAME_W) ? 12'(BUTTONS_X - FRAME_W) : 12'd0;
  localparam logic [11:0] X_HI_OUT = 12'(BUTTONS_X + BUTTONS_W + FRAME_W);
  localparam logic [11:0] X_LO_IN  = 12'(BUTTONS_X);
  localparam logic [11:0] X_HI_IN  = 12'(BUTTONS_X + BUTTONS_W);

  state_t          state, state_nxt;
  logic [1:0]      sel, sel_nxt, sel_inc, sel_dec;
  logic [1:0]      choice, choice_nxt;
  logic            choice_valid, valid_nxt;
  logic [FC_W-1:0] frame_cnt, frame_cnt_nxt;
  logic [BC_W-1:0] blink_cnt, blink_cnt_nxt;
  logic            blink_on, blink_on_nxt;
  logic [1:0]      disp_sel;
  logic            vblnk_d;
  logic            frame_tick;

  logic [11:0] hc, vc, btn_y, y_lo_out, y_hi_out, y_hi_in;
  logic        in_outer, in_inner, in_hl, frame_vis;
  logic [RGB_B-1:0] rgb_nxt;

  assign frame_tick = vga_in.vblnk & ~vblnk_d;
  assign sel_inc    = (sel >= SEL_MAX) ? SEL_ABOVE_MAX : sel + 2'd1;
  assign sel_dec    = (sel == 2'd0)    ? SEL_BELOW_MIN : sel - 2'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= BROWSE;
      sel          <= 2'd0;
      choice       <= 2'd0;
      choice_valid <= 1'b0;
      frame_cnt    <= '0;
      blink_cnt    <= '0;
      blink_on     <= 1'b1;
    end else begin
      state        <= state_nxt;
      sel          <= sel_nxt;
      choice       <= choice_nxt;
      choice_valid <= valid_nxt;
      frame_cnt    <= frame_cnt_nxt;
      blink_cnt    <= blink_cnt_nxt;
      blink_on     <= blink_on_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sel_nxt       = sel;
    choice_nxt    = choice;
    valid_nxt     = choice_valid;
    frame_cnt_nxt = frame_cnt;
    blink_cnt_nxt = blink_cnt;
    blink_on_nxt  = blink_on;
    if (!en) begin
      state_nxt     = BROWSE;
      valid_nxt     = 1'b0;
      frame_cnt_nxt = '0;
      blink_cnt_nxt = '0;
      blink_on_nxt  = 1'b1;
    end else begin
      case (state)
        BROWSE: begin
          if (btn_enter) begin
            choice_nxt    = sel;
            frame_cnt_nxt = '0;
            blink_cnt_nxt = '0;
            blink_on_nxt  = 1'b1;
            state_nxt     = CONFIRM;
          end else if (btn_up && !btn_down) begin
            sel_nxt = sel_dec;
          end else if (btn_down && !btn_up) begin
            sel_nxt = sel_inc;
          end
        end
        CONFIRM: begin
          if (frame_tick) begin
            if (frame_cnt == FC_LAST) begin
              frame_cnt_nxt = '0;
              blink_on_nxt  = ~blink_on;
              blink_cnt_nxt = blink_cnt + 1'b1;
              if (blink_cnt == BC_LAST) begin
                valid_nxt = 1'b1;
                state_nxt = DONE;
              end
            end else begin
              frame_cnt_nxt = frame_cnt + 1'b1;
            end
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Highlight only follows sel at frame boundaries so it never tears mid-frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblnk_d  <= 1'b0;
      disp_sel <= 2'd0;
    end else begin
      vblnk_d <= vga_in.vblnk;
      if (frame_tick) disp_sel <= sel;
    end
  end

  always_comb begin
    case (disp_sel)
      2'd1:    btn_y = 12'(BUTTON2_Y);
      2'd2:    btn_y = 12'(BUTTON3_Y);
      default: btn_y = 12'(BUTTON1_Y);
    endcase
    y_lo_out = (btn_y >= 12'(FRAME_W)) ? btn_y - 12'(FRAME_W) : 12'd0;
    y_hi_out = btn_y + 12'(BUTTONS_H + FRAME_W);
    y_hi_in  = btn_y + 12'(BUTTONS_H);
  end

  assign hc        = {1'b0, vga_in.hcount};
  assign vc        = {1'b0, vga_in.vcount};
  assign in_outer  = (hc >= X_LO_OUT) && (hc < X_HI_OUT) && (vc >= y_lo_out) && (vc < y_hi_out);
  assign in_inner  = (hc >= X_LO_IN) && (hc < X_HI_IN) && (vc >= btn_y) && (vc < y_hi_in);
  assign in_hl     = in_outer && !in_inner;
  assign frame_vis = (state != CONFIRM) || blink_on;

  always_comb begin
    rgb_nxt = rgb_i;
    if (vga_in.hblnk || vga_in.vblnk) begin
      rgb_nxt = '0;
    end else if (in_hl && frame_vis) begin
      rgb_nxt = HL_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      rgb_o          <= '0;
    end else begin
      vga_out.hcount <= vga_in.hcount;
      vga_out.vcount <= vga_in.vcount;
      vga_out.hsync  <= vga_in.hsync;
      vga_out.vsync  <= vga_in.vsync;
      vga_out.hblnk  <= vga_in.hblnk;
      vga_out.vblnk  <= vga_in.vblnk;
      rgb_o          <= rgb_nxt;
    end
  end

  assign sel_o          = sel;
  assign choice_o       = choice;
  assign choice_valid_o = choice_valid;

endmodule

// File: tb/tb_draw_menu_select.sv
// Scoreboard bench for draw_menu_select: pixel/timing expectations queued at drive time,
// popped one cycle later; navigation and blink timing predicted from the menu behaviour.
module tb_draw_menu_select;
  import snake_pkg::*;

  localparam logic [11:0] HL = 12'hF00;
  localparam int FW = 4;
  localparam int BF = 8;
  localparam int N_TOGGLES = 6;
`ifdef MENU_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic        btn_enter = 1'b0;
  logic [11:0] rgb_i = '0;
  logic [11:0] rgb_o;
  logic [1:0]  sel_o;
  logic [1:0]  choice_o;
  logic        choice_valid_o;

  vga_if vga_in ();
  vga_if vga_out ();

  draw_menu_select dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .btn_up         (btn_up),
    .btn_down       (btn_down),
    .btn_enter      (btn_enter),
    .vga_in         (vga_in),
    .rgb_i          (rgb_i),
    .vga_out        (vga_out),
    .rgb_o          (rgb_o),
    .sel_o          (sel_o),
    .choice_o       (choice_o),
    .choice_valid_o (choice_valid_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] q_rgb [$];
  logic [25:0] q_vga [$];

  int exp_sel = 0, exp_disp = 0, exp_choice = 0, t_blink = 0;
  bit exp_valid = 0, exp_vis = 1, in_confirm = 0, done = 0, prev_vb = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit in_hl(input int x, input int y, input int k);
    int by, xlo, ylo;
    bit outer, inner;
    by  = (k == 1) ? BUTTON2_Y : (k == 2) ? BUTTON3_Y : BUTTON1_Y;
    xlo = (BUTTONS_X - FW < 0) ? 0 : BUTTONS_X - FW;
    ylo = (by - FW < 0) ? 0 : by - FW;
    outer = (x >= xlo) && (x < BUTTONS_X + BUTTONS_W + FW) && (y >= ylo) && (y < by + BUTTONS_H + FW);
    inner = (x >= BUTTONS_X) && (x < BUTTONS_X + BUTTONS_W) && (y >= by) && (y < by + BUTTONS_H);
    return outer && !inner;
  endfunction

  function automatic logic [11:0] exp_pix(input int x, input int y, input bit hb, input bit vb,
                                          input logic [11:0] c);
    if (hb || vb) return 12'h000;
    if (in_hl(x, y, exp_disp) && exp_vis) return HL;
    return c;
  endfunction

  function automatic int next_sel(input int s, input bit up, input bit dn);
    if (up && dn) return s;
    if (up) return (s == 0) ? (WRAP ? 2 : 0) : s - 1;
    if (dn) return (s == 2) ? (WRAP ? 0 : 2) : s + 1;
    return s;
  endfunction

  task automatic step(input int x, input int y, input bit hb, input bit vb, input logic [11:0] c,
                      input bit up, input bit dn, input bit ent);
    int  old_sel;
    bit  tick;
    logic [25:0] got_vga;
    vga_in.hcount = 11'(x);
    vga_in.vcount = 11'(y);
    vga_in.hsync  = x[1];
    vga_in.vsync  = y[1];
    vga_in.hblnk  = hb;
    vga_in.vblnk  = vb;
    rgb_i     = c;
    btn_up    = up;
    btn_down  = dn;
    btn_enter = ent;
    q_rgb.push_back(exp_pix(x, y, hb, vb, c));
    q_vga.push_back({x[1], y[1], hb, vb, 11'(y), 11'(x)});
    old_sel = exp_sel;
    tick    = vb && !prev_vb;
    prev_vb = vb;
    if (tick) exp_disp = old_sel;
    if (!en) begin
      in_confirm = 0; done = 0; exp_valid = 0; exp_vis = 1;
    end else if (in_confirm) begin
      if (tick) begin
        t_blink++;
        if (t_blink == N_TOGGLES * BF) begin
          in_confirm = 0; done = 1; exp_valid = 1; exp_vis = 1;
        end else begin
          exp_vis = ((t_blink / BF) % 2) == 0;
        end
      end
    end else if (!done) begin
      if (ent) begin
        exp_choice = old_sel; in_confirm = 1; t_blink = 0; exp_vis = 1;
      end else begin
        exp_sel = next_sel(old_sel, up, dn);
      end
    end
    @(posedge clk);
    #1;
    btn_up = 0; btn_down = 0; btn_enter = 0;
    got_vga = {vga_out.hsync, vga_out.vsync, vga_out.hblnk, vga_out.vblnk,
               vga_out.vcount, vga_out.hcount};
    check_val("rgb", rgb_o, q_rgb.pop_front());
    check_val("vga_delay", got_vga, q_vga.pop_front());
    check_val("sel", sel_o, exp_sel);
    check_val("choice", choice_o, exp_choice);
    check_val("valid", choice_valid_o, exp_valid);
  endtask

  task automatic frame();
    step(5, 610, 1'b1, 1'b1, 12'h777, 0, 0, 0);
    step(5, 611, 1'b1, 1'b0, 12'h777, 0, 0, 0);
  endtask

  task automatic check_points(input int k);
    int by;
    by = (k == 1) ? BUTTON2_Y : (k == 2) ? BUTTON3_Y : BUTTON1_Y;
    step(BUTTONS_X - FW,             by - FW,             0, 0, 12'h101, 0, 0, 0);
    step(BUTTONS_X - FW - 1,         by,                  0, 0, 12'h202, 0, 0, 0);
    step(BUTTONS_X + BUTTONS_W + FW - 1, by + BUTTONS_H + FW - 1, 0, 0, 12'h303, 0, 0, 0);
    step(BUTTONS_X + BUTTONS_W + FW, by,                  0, 0, 12'h404, 0, 0, 0);
    step(BUTTONS_X,                  by,                  0, 0, 12'h505, 0, 0, 0);
    step(BUTTONS_X + BUTTONS_W - 1,  by + BUTTONS_H - 1,  0, 0, 12'h606, 0, 0, 0);
    step(BUTTONS_X + 5,              by - 1,              0, 0, 12'h707, 0, 0, 0);
    step(BUTTONS_X + 5,              by + BUTTONS_H,      0, 0, 12'h808, 0, 0, 0);
    step(BUTTONS_X + 5,              by + BUTTONS_H + FW, 0, 0, 12'h909, 0, 0, 0);
  endtask

  task automatic reset_model();
    exp_sel = 0; exp_disp = 0; exp_choice = 0; t_blink = 0;
    exp_valid = 0; exp_vis = 1; in_confirm = 0; done = 0; prev_vb = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [25:0] got_vga;
    got_vga = {vga_out.hsync, vga_out.vsync, vga_out.hblnk, vga_out.vblnk,
               vga_out.vcount, vga_out.hcount};
    check_val({tag, "_rgb"}, rgb_o, 0);
    check_val({tag, "_vga"}, got_vga, 0);
    check_val({tag, "_sel"}, sel_o, 0);
    check_val({tag, "_choice"}, choice_o, 0);
    check_val({tag, "_valid"}, choice_valid_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] nav [8];
    nav[0] = 2'b01; nav[1] = 2'b01; nav[2] = 2'b10; nav[3] = 2'b10;
    nav[4] = 2'b10; nav[5] = 2'b10; nav[6] = 2'b11; nav[7] = 2'b01;

    vga_in.hcount = 11'd123; vga_in.vcount = 11'd45;
    vga_in.hsync = 1'b1; vga_in.vsync = 1'b1; vga_in.hblnk = 1'b0; vga_in.vblnk = 1'b0;
    rgb_i = 12'hABC;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    frame();
    check_points(0);
    step(BUTTONS_X - 1, BUTTON1_Y, 1'b1, 1'b0, 12'h0A5, 0, 0, 0);

    // Selection moves now, highlight only after the next frame tick.
    step(BUTTONS_X - 1, BUTTON2_Y, 0, 0, 12'h0A5, 0, 1, 0);
    check_val("sel_after_down", sel_o, 1);
    step(BUTTONS_X - 1, BUTTON1_Y, 0, 0, 12'h0A5, 0, 0, 0);
    frame();
    step(BUTTONS_X - 1, BUTTON2_Y, 0, 0, 12'h0A5, 0, 0, 0);
    check_val("hl_moved_btn2", rgb_o, HL);
    check_points(1);
    step(BUTTONS_X - 1, BUTTON1_Y, 0, 0, 12'h0A5, 0, 0, 0);

    for (int i = 0; i < 8; i++)
      step(10, 10, 0, 0, 12'h555, nav[i][1], nav[i][0], 0);

    for (int i = 0; i < 4 && exp_sel != 1; i++)
      step(10, 10, 0, 0, 12'h555, 0, 1, 0);
    frame();

    step(10, 10, 0, 0, 12'h555, 0, 1, 1);
    check_val("enter_choice", choice_o, 1);

    for (int f = 0; f < N_TOGGLES * BF; f++) begin
      frame();
      step(BUTTONS_X - 1, BUTTON2_Y, 0, 0, 12'h0A5, (f == 3), (f == 5), (f == 7));
    end
    check_val("done_valid", choice_valid_o, 1);
    check_val("done_choice", choice_o, 1);

    step(10, 10, 0, 0, 12'h555, 0, 1, 1);
    step(10, 10, 0, 0, 12'h555, 1, 0, 0);

    en = 1'b0;
    step(10, 10, 0, 0, 12'h555, 0, 0, 0);
    check_val("en_low_valid", choice_valid_o, 0);
    en = 1'b1;

    step(10, 10, 0, 0, 12'h555, 0, 0, 1);
    for (int f = 0; f < 10; f++) begin
      frame();
      step(BUTTONS_X - 1, BUTTON2_Y, 0, 0, 12'h0A5, 0, 0, 0);
    end
    step(10, 10, 0, 0, 12'hABC, 0, 0, 0);

    #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    reset_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    frame();
    step(BUTTONS_X - 1, BUTTON1_Y, 0, 0, 12'h0A5, 0, 0, 0);
    check_val("post_rst_hl_btn1", rgb_o, HL);
    step(10, 10, 0, 0, 12'h555, 0, 1, 0);
    check_val("post_rst_browse", sel_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
